// File: rtl/fm_demod_pkg.sv
// Shared phase/magnitude types for the FM demodulation chain.
// phase_diff() gives the wrapped signed difference between two full-turn angles.
package fm_demod_pkg;

    localparam int PHASE_W = 32;
    localparam int MAG_W   = 32;

    typedef logic        [PHASE_W-1:0] phase_t;
    typedef logic signed [PHASE_W-1:0] dphase_t;
    typedef logic        [MAG_W-1:0]   mag_t;

    // Modulo-2^32 subtraction read as signed wraps cleanly across +/-pi.
    function automatic dphase_t phase_diff(phase_t a, phase_t b);
        return dphase_t'(a - b);
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register with valid/ready/tlast.
// A load always wins over a drain, so load and accept together reload with no bubble.
module axis_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              can_load,
    output logic              tvalid,
    input  logic              tready,
    output logic [DATA_W-1:0] tdata,
    output logic              tlast
);

    assign can_load = !tvalid || tready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tlast  <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= load_data;
            tlast  <= load_last;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/fm_discriminator.sv
// FM discriminator: wrapped phase difference of consecutive CORDIC angles, averaged over 2^C_DECIM_LOG2.
// Optional build macro FM_SQUELCH_EN zeroes the difference of words whose magnitude is below C_SQUELCH_THRESH.
module fm_discriminator
    import fm_demod_pkg::*;
#(
    parameter int          C_S00_AXIS_TDATA_WIDTH = 64,
    parameter int          C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int          C_DECIM_LOG2           = 3,
    parameter logic [31:0] C_SQUELCH_THRESH       = 32'd100
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic                                  s00_axis_tvalid,
    output logic                                  s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic                                  s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    output logic                                  m00_axis_tvalid,
    input  logic                                  m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic                                  m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb
);

    localparam int ACC_W = PHASE_W + C_DECIM_LOG2;
    localparam int CNT_W = (C_DECIM_LOG2 > 0) ? C_DECIM_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << C_DECIM_LOG2) - 1);

    phase_t                   angle;
    phase_t                   prev_angle;
    mag_t                     mag;
    dphase_t                  diff;
    dphase_t                  diff_eff;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]         cnt;
    logic                     prev_valid;
    logic                     last_sticky;
    logic                     group_last;
    logic                     accept;
    logic                     group_done;
    logic                     can_load;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] avg_word;
    logic                     unused_bits;

    assign angle = s00_axis_tdata[PHASE_W+MAG_W-1:MAG_W];
    assign mag   = s00_axis_tdata[MAG_W-1:0];
    assign diff  = phase_diff(angle, prev_angle);

`ifdef FM_SQUELCH_EN
    assign diff_eff = (mag < C_SQUELCH_THRESH) ? '0 : diff;
`else
    assign diff_eff = diff;
`endif

    assign unused_bits = ^{s00_axis_tstrb, mag, C_SQUELCH_THRESH};

    assign s00_axis_tready = s00_axis_aresetn && can_load;
    assign accept          = s00_axis_tvalid && s00_axis_tready;
    assign group_done      = accept && prev_valid && (cnt == CNT_LAST);
    assign group_last      = last_sticky | s00_axis_tlast;
    assign acc_sum         = acc + ACC_W'(diff_eff);
    // Taking bits [L+31:L] of the full-width sum is the arithmetic shift, floor-rounded.
    assign avg_word        = acc_sum[PHASE_W-1+C_DECIM_LOG2:C_DECIM_LOG2];
    assign m00_axis_tstrb  = '1;

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            prev_angle  <= '0;
            prev_valid  <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            last_sticky <= 1'b0;
        end else if (accept) begin
            prev_angle <= angle;
            prev_valid <= 1'b1;
            if (!prev_valid) begin
                last_sticky <= group_last;
            end else if (group_done) begin
                acc         <= '0;
                cnt         <= '0;
                last_sticky <= 1'b0;
            end else begin
                acc         <= acc_sum;
                cnt         <= cnt + CNT_W'(1);
                last_sticky <= group_last;
            end
        end
    end

    axis_out_reg #(
        .DATA_W (C_M00_AXIS_TDATA_WIDTH)
    ) u_out_reg (
        .aclk      (s00_axis_aclk),
        .aresetn   (s00_axis_aresetn),
        .load      (group_done),
        .load_data (avg_word),
        .load_last (group_last),
        .can_load  (can_load),
        .tvalid    (m00_axis_tvalid),
        .tready    (m00_axis_tready),
        .tdata     (m00_axis_tdata),
        .tlast     (m00_axis_tlast)
    );

endmodule

// File: tb/tb_fm_discriminator.sv
// Self-checking bench for fm_discriminator: directed cases plus randomized traffic
// scored against a behavioural model of the averaged phase-difference stream.
module tb_fm_discriminator;

    logic        clk;
    logic        rst_n;

    logic        s_tvalid, s_tready, s_tlast;
    logic [63:0] s_tdata;
    logic [7:0]  s_tstrb;
    logic        m_tvalid, m_tready, m_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;

    logic        z_tvalid, z_tready, z_tlast;
    logic [63:0] z_tdata;
    logic [7:0]  z_tstrb;
    logic        z_m_tvalid, z_m_tready, z_m_tlast;
    logic [31:0] z_m_tdata;
    logic [3:0]  z_m_tstrb;

    int checks = 0;
    int errors = 0;

    fm_discriminator #(.C_DECIM_LOG2(3)) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis_tvalid  (s_tvalid),
        .s00_axis_tready  (s_tready),
        .s00_axis_tdata   (s_tdata),
        .s00_axis_tlast   (s_tlast),
        .s00_axis_tstrb   (s_tstrb),
        .m00_axis_tvalid  (m_tvalid),
        .m00_axis_tready  (m_tready),
        .m00_axis_tdata   (m_tdata),
        .m00_axis_tlast   (m_tlast),
        .m00_axis_tstrb   (m_tstrb)
    );

    fm_discriminator #(.C_DECIM_LOG2(0)) dut0 (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis_tvalid  (z_tvalid),
        .s00_axis_tready  (z_tready),
        .s00_axis_tdata   (z_tdata),
        .s00_axis_tlast   (z_tlast),
        .s00_axis_tstrb   (z_tstrb),
        .m00_axis_tvalid  (z_m_tvalid),
        .m00_axis_tready  (z_m_tready),
        .m00_axis_tdata   (z_m_tdata),
        .m00_axis_tlast   (z_m_tlast),
        .m00_axis_tstrb   (z_m_tstrb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: every accepted word after the first yields a wrapped signed
    // difference; each run of 8 differences is averaged with floor rounding.
    logic [31:0] exp_data[$];
    logic        exp_last[$];
    bit          mdl_primed;
    logic [31:0] mdl_prev;
    longint      mdl_sum;
    int          mdl_n;
    bit          mdl_last;
    int          out_cnt  = 0;
    int          push_cnt = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mdl_primed = 0;
            mdl_sum    = 0;
            mdl_n      = 0;
            mdl_last   = 0;
            exp_data.delete();
            exp_last.delete();
        end else begin
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                if (exp_data.size() == 0) begin
                    check_eq("spurious_out", {31'd0, m_tvalid}, 32'd0);
                end else begin
                    check_eq("sb_data", m_tdata, exp_data.pop_front());
                    check_eq("sb_last", {31'd0, m_tlast}, {31'd0, exp_last.pop_front()});
                    out_cnt++;
                end
            end
            if (s_tvalid === 1'b1 && s_tready === 1'b1) begin
                logic [31:0] ang, mg;
                int          d;
                longint      sh;
                ang = s_tdata[63:32];
                mg  = s_tdata[31:0];
                mdl_last = mdl_last | s_tlast;
                if (!mdl_primed) begin
                    mdl_primed = 1;
                end else begin
                    d = $signed(ang - mdl_prev);
`ifdef FM_SQUELCH_EN
                    if (mg < 32'd100) d = 0;
`endif
                    mdl_sum += d;
                    mdl_n++;
                    if (mdl_n == 8) begin
                        sh = mdl_sum >>> 3;
                        exp_data.push_back(sh[31:0]);
                        exp_last.push_back(mdl_last);
                        push_cnt++;
                        mdl_sum  = 0;
                        mdl_n    = 0;
                        mdl_last = 0;
                    end
                end
                mdl_prev = ang;
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input bit sel, input logic [31:0] ang, input logic [31:0] mag, input logic lst);
        bit ok;
        ok = 0;
        if (sel) begin z_tvalid = 1; z_tdata = {ang, mag}; z_tlast = lst; end
        else     begin s_tvalid = 1; s_tdata = {ang, mag}; s_tlast = lst; end
        for (int i = 0; i < 200 && !ok; i++) begin
            #1;
            if (sel ? z_tready : s_tready) begin
                @(posedge clk);
                ok = 1;
            end
            @(negedge clk);
        end
        if (sel) begin z_tvalid = 0; z_tlast = 0; end
        else     begin s_tvalid = 0; s_tlast = 0; end
        if (!ok) check_eq("send_timeout", {31'd0, ok}, 32'd1);
    endtask

    localparam logic [31:0] STEP = 32'h0100_0000;
    bit          rand_on = 0;
    logic [31:0] ang;
    logic [31:0] sq_exp;

    initial begin
        s_tvalid = 0; s_tdata = '0; s_tlast = 0; s_tstrb = 8'hff;
        z_tvalid = 0; z_tdata = '0; z_tlast = 0; z_tstrb = 8'hff;
        m_tready = 1; z_m_tready = 1;
        rst_n = 0;
        repeat (3) @(negedge clk);

        s_tvalid = 1;
        #1;
        check_eq("rst_s_tready", {31'd0, s_tready}, 32'd0);
        check_eq("rst_tvalid",   {31'd0, m_tvalid}, 32'd0);
        check_eq("rst_tdata",    m_tdata, 32'd0);
        check_eq("rst_tlast",    {31'd0, m_tlast}, 32'd0);
        check_eq("tstrb",        {28'd0, m_tstrb}, 32'hf);
        s_tvalid = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Constant step: prime + 8 diffs gives one output one cycle after the 9th accept.
        ang = 0;
        for (int i = 0; i < 9; i++) begin
            send(0, ang, 32'd1000, 0);
            if (i < 8) check_eq("step_no_out", {31'd0, m_tvalid}, 32'd0);
            ang += STEP;
        end
        check_eq("step_valid", {31'd0, m_tvalid}, 32'd1);
        check_eq("step_data",  m_tdata, STEP);
        check_eq("step_last",  {31'd0, m_tlast}, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("step_count", out_cnt, 32'd1);

        // Wrap-around on the undecimated instance.
        send(1, 32'hF000_0000, 32'd1000, 0);
        check_eq("wrap_prime", {31'd0, z_m_tvalid}, 32'd0);
        send(1, 32'h1000_0000, 32'd1000, 0);
        check_eq("wrap_pos_v", {31'd0, z_m_tvalid}, 32'd1);
        check_eq("wrap_pos",   z_m_tdata, 32'h2000_0000);
        send(1, 32'hF000_0000, 32'd1000, 0);
        check_eq("wrap_neg",   z_m_tdata, 32'hE000_0000);

        // Backpressure: a pending output stalls the input and holds its data.
        m_tready = 0;
        for (int i = 0; i < 8; i++) begin
            send(0, ang, 32'd1000, 0);
            ang += STEP;
        end
        s_tvalid = 1; s_tdata = {ang, 32'd1000};
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check_eq("bp_s_tready", {31'd0, s_tready}, 32'd0);
            check_eq("bp_tvalid",   {31'd0, m_tvalid}, 32'd1);
            check_eq("bp_tdata",    m_tdata, STEP);
        end
        s_tvalid = 0;
        m_tready = 1;
        for (int i = 0; i < 8; i++) begin
            send(0, ang, 32'd1000, 0);
            ang += STEP;
        end
        check_eq("bp_resume_v", {31'd0, m_tvalid}, 32'd1);
        check_eq("bp_resume",   m_tdata, STEP);

        // tlast on the 4th diff marks only this group's output.
        for (int i = 0; i < 8; i++) begin
            send(0, ang, 32'd1000, (i == 3));
            ang += STEP;
        end
        check_eq("tlast_set", {31'd0, m_tlast}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            send(0, ang, 32'd1000, 0);
            ang += STEP;
        end
        check_eq("tlast_clr_v", {31'd0, m_tvalid}, 32'd1);
        check_eq("tlast_clr",   {31'd0, m_tlast}, 32'd0);

        // Reset mid-group: next output needs a fresh prime plus 8 diffs.
        for (int i = 0; i < 5; i++) begin
            send(0, ang, 32'd1000, 0);
            ang += STEP;
        end
        rst_n = 0;
        @(negedge clk);
        #1;
        check_eq("mid_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        check_eq("mid_rst_tready", {31'd0, s_tready}, 32'd0);
        rst_n = 1;
        @(negedge clk);
        ang = 32'h7F00_0000;
        for (int i = 0; i < 9; i++) begin
            send(0, ang, 32'd1000, 0);
            if (i < 8) check_eq("mid_rst_no_out", {31'd0, m_tvalid}, 32'd0);
            ang += STEP;
        end
        check_eq("mid_rst_out", m_tdata, STEP);

        // Low-magnitude words: squelched only when the feature is built in.
`ifdef FM_SQUELCH_EN
        sq_exp = 32'd0;
`else
        sq_exp = STEP;
`endif
        for (int i = 0; i < 8; i++) begin
            send(0, ang, 32'd10, 0);
            ang += STEP;
        end
        check_eq("squelch_low", m_tdata, sq_exp);
        for (int i = 0; i < 8; i++) begin
            send(0, ang, 32'd1000, 0);
            ang += STEP;
        end
        check_eq("squelch_high", m_tdata, STEP);

        // Randomized traffic with random downstream stalls.
        rand_on = 1;
        fork
            begin
                for (int i = 0; i < 1200; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    send(0, $urandom, $urandom_range(0, 200), ($urandom_range(0, 7) == 0));
                end
                rand_on = 0;
            end
            begin
                while (rand_on) begin
                    @(negedge clk);
                    m_tready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_tready = 1;
        repeat (5) @(negedge clk);
        check_eq("sb_drain", exp_data.size(), 32'd0);
        check_eq("sb_count", out_cnt, push_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fm_discriminator.md
Name: fm_discriminator

Overview:
- Downstream neighbour of the CORDIC rectangular-to-polar stage in the FM receive chain.
- Consumes the CORDIC's {angle, magnitude} AXI-Stream words and computes the wrapped phase difference between consecutive samples, i.e. instantaneous frequency.
- Averages groups of 2^C_DECIM_LOG2 differences and emits one signed 32-bit demodulated audio sample per group.
- Implements full AXI-Stream backpressure on both sides.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 64, input width; [31:0] magnitude, [63:32] angle.
- C_M00_AXIS_TDATA_WIDTH, 32, output width; signed averaged phase difference.
- C_DECIM_LOG2, 3, log2 of decimation factor; legal range 0..8, where 0 means one output per difference.
- C_SQUELCH_THRESH, 32'd100, magnitude threshold; used only when FM_SQUELCH_EN is defined.

Ports:
- s00_axis_aclk  in  1  single clock.
- s00_axis_aresetn  in  1  reset; synchronous, active-low.
- s00_axis_tvalid  in  1  input word valid.
- s00_axis_tready  out  1  input accept.
- s00_axis_tdata  in  64  {angle[31:0] unsigned (2^32 = full turn), mag[31:0] unsigned}.
- s00_axis_tlast  in  1  end-of-packet marker.
- s00_axis_tstrb  in  8  ignored.
- m00_axis_tvalid  out  1  output valid.
- m00_axis_tready  in  1  downstream accept.
- m00_axis_tdata  out  32  signed average of phase differences.
- m00_axis_tlast  out  1  packet end.
- m00_axis_tstrb  out  4  constant 4'hf.

Behaviour:
- **Reset** (sampled on a clock edge with aresetn=0):
  - Outputs: m00_axis_tvalid=0, m00_axis_tdata=0, m00_axis_tlast=0.
  - Internal state: prev_valid=0, accumulator=0, group count=0, sticky tlast=0.
  - s00_axis_tready=0 while aresetn=0.
  - A reset in mid-group discards the partial group and any pending output word.
- **Handshake**:
  - s00_axis_tready = aresetn && (!m00_axis_tvalid || m00_axis_tready), combinational.
  - A word is accepted when s00_axis_tvalid && s00_axis_tready.
  - The output register holds tdata and tlast stable while tvalid && !tready.
- **Priming**: the first accepted word after reset only loads prev_angle and sets prev_valid. It produces no difference and does not advance the count.
- **Difference**: for each later accepted word, diff = angle - prev_angle, computed modulo 2^32 and interpreted as signed 32-bit. This wraps naturally across ±pi; for example 0x10000000 - 0xF0000000 = +0x20000000. prev_angle then takes the new angle.
- **Accumulator**:
  - Signed, 32+C_DECIM_LOG2 bits wide, so it never overflows.
  - The count runs from 0 to 2^C_DECIM_LOG2-1.
  - On the diff that completes a group: m00_axis_tdata <= (acc + diff) >>> C_DECIM_LOG2 (arithmetic shift, rounds toward -inf, low 32 bits). Also m00_axis_tvalid <= 1, acc <= 0, count <= 0.
  - Otherwise acc <= acc + diff and count++.
- **Latency**: the output is valid on the cycle after the edge that accepts the group-completing word.
- **tlast**:
  - Sticky OR of s00_axis_tlast over the words accepted in the current group, including a priming word.
  - Driven on m00_axis_tlast with that group's output, then cleared.
  - tlast does not reset prev_valid.
- **Output release**: m00_axis_tvalid drops when m00_axis_tready=1 and no new group completes in the same cycle. Simultaneous output accept and group completion reloads the register back-to-back with no bubble.

Optional Feature:
- FM_SQUELCH_EN defined:
  - A word with mag < C_SQUELCH_THRESH contributes diff=0, but still updates prev_angle and counts toward the group.
  - This keeps output cadence constant while noise is suppressed.
- Undefined: magnitude bits are ignored entirely.

Decomposition:
- Package fm_demod_pkg holds:
  - PHASE_W=32 and MAG_W=32.
  - typedefs phase_t (logic [31:0]), dphase_t (logic signed [31:0]) and mag_t.
  - function phase_diff(phase_t a, phase_t b) returning dphase_t.
- One natural sub-module: axis_out_reg. It is a single-entry output register with valid/ready/tlast, reusable by other chain stages.

Test Plan:
- **Reset, constant step**: reset, then angles 0, 0x01000000, 0x02000000, … (9 words, m_tready=1) -> exactly one output, tdata=0x01000000, tlast=0, one cycle after 9th accept.
- **Wrap-around** (bench instance C_DECIM_LOG2=0): angles 0xF0000000 then 0x10000000 -> 0x20000000. Then angle 0xF0000000 -> 0xE0000000 (-0x20000000).
- **Backpressure**: m_tready=0 while an output is pending -> s_tready=0, tdata stable for 20 cycles. Release -> stream resumes and a constant-step sequence yields identical outputs, with no sample lost.
- **tlast**: tlast=1 on the 4th diff of a group -> that group's output has m00_axis_tlast=1. The next group's output has tlast=0.
- **Reset mid-group**: aresetn=0 for one cycle after 5 diffs -> tvalid=0. The next output requires 1 priming word + 8 diffs.
- **Squelch** (FM_SQUELCH_EN defined): step 0x01000000, with words 2..9 at mag=10 -> output 0. With mag=1000 -> output 0x01000000.
